// File: rtl/ir_queue.sv
// ir_queue: DEPTH-entry instruction/PC queue between fetch and decode, NOP when empty, single-cycle flush.
module ir_queue #(
  parameter int               WIDTH    = 32,
  parameter int               PC_WIDTH = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] NOP      = 32'h00000013
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_enq_valid,
  output logic                         io_enq_ready,
  input  logic [WIDTH-1:0]             io_enq_bits,
  input  logic [PC_WIDTH-1:0]          io_enq_pc,
  output logic                         io_deq_valid,
  input  logic                         io_deq_ready,
  output logic [WIDTH-1:0]             io_deq_bits,
  output logic [PC_WIDTH-1:0]          io_deq_pc,
  input  logic                         io_flush,
  output logic [$clog2(DEPTH+1)-1:0]   io_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0]    mem_bits [DEPTH];
  logic [PC_WIDTH-1:0] mem_pc   [DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count;
  logic                enq, deq;
  // ready depends only on count, so there is no deq_ready -> enq_ready path
  assign io_enq_ready = count != CW'(DEPTH);
  assign io_deq_valid = count != '0;
  assign io_count     = count;
  assign io_deq_bits  = io_deq_valid ? mem_bits[rd_ptr] : NOP;
  assign io_deq_pc    = io_deq_valid ? mem_pc[rd_ptr] : '0;
  assign enq = io_enq_valid && io_enq_ready;
  assign deq = io_deq_valid && io_deq_ready;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_bits[i] <= NOP;
        mem_pc[i]   <= '0;
      end
    end else if (io_flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        mem_bits[wr_ptr] <= io_enq_bits;
        mem_pc[wr_ptr]   <= io_enq_pc;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(enq) - CW'(deq);
    end
  end
endmodule
